// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the multiply/divide unit
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
import muldiv_pkg::*;

module muldiv_step #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             is_div_i,
  output logic [2*WIDTH:0] acc_o
);

  // Accumulator layout:
  //   multiply: {carry, partial product (WIDTH), multiplier bits still to consume (WIDTH)}
  //   divide:   {remainder (WIDTH+1), dividend bits shifting out / quotient bits shifting in (WIDTH)}
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Single iteration: conditional add then right shift, or left shift then trial subtract/restore
  always_comb begin
    acc_o   = '0;
    add_sum = acc_i[2*WIDTH:WIDTH];
    if (acc_i[0]) begin
      add_sum = acc_i[2*WIDTH:WIDTH] + {1'b0, operand_i};
    end
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, operand_i};
    if (is_div_i) begin
      if (rem_sh >= {1'b0, operand_i}) begin
        acc_o = {trial, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh, acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   acc_q;
  logic [2*WIDTH:0]   acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_q_q;   // negate product / quotient
  logic               neg_r_q;   // negate remainder
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               signed_op;
  logic               div_op;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Operand decode: magnitudes for signed ops, raw values otherwise
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op && busA[WIDTH-1];
    b_neg     = signed_op && busB[WIDTH-1];
    b_zero    = (busB == '0);
    mag_a     = a_neg ? -busA : busA;
    mag_b     = b_neg ? -busB : busB;
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (acc_d)
  );

  // Sign correction of the finished magnitude result
  always_comb begin
    prod_fix = neg_q_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM, iteration counter and HI/LO; reset beats cancel beats normal sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        // Flush: drop any operation in flight and block a same-cycle issue
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              case (op)
                OP_MTHI: hi_q <= busA;
                OP_MTLO: lo_q <= busA;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  is_div_q <= div_op;
                  if (div_op) begin
                    acc_q  <= {{(WIDTH+1){1'b0}}, mag_a};
                    opnd_q <= mag_b;
                    // A zero divisor leaves the quotient as all ones; the
                    // remainder correction still restores the original dividend
                    neg_q_q <= (a_neg ^ b_neg) && !b_zero;
                    neg_r_q <= a_neg;
                  end else begin
                    acc_q   <= {{(WIDTH+1){1'b0}}, mag_b};
                    opnd_q  <= mag_a;
                    neg_q_q <= a_neg ^ b_neg;
                    neg_r_q <= 1'b0;
                  end
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
                end
                default: ;
              endcase
            end
          end
          S_CALC: begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
              state_q <= S_FINISH;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_FINISH: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
import muldiv_pkg::*;

module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;
  int lat;
  int busy_cnt;
  int done_seen;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .busA   (busA),
    .busB   (busB),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds start across one rising edge, returns at the next negedge
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    busA  = a;
    busB  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen; also counts negedge samples with busy high
  task automatic wait_done(output int cycles, output int bcnt);
    cycles = 0;
    bcnt   = busy ? 1 : 0;
    while (cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done) break;
      if (busy) bcnt++;
    end
    if (!done) chk("timeout", 32'(cycles), 32'd0);
  endtask

  task automatic watch_no_done(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cancel   = 1'b0;
    op       = 3'b000;
    busA     = '0;
    busB     = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max * max, latency and busy window
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, busy_cnt);
    chk("multu_lat", 32'(lat), 32'd33);
    chk("multu_busy_cycles", 32'(busy_cnt), 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_busy_at_done", 32'(busy), 32'h0);

    // Signed multiply issued in the done cycle
    start_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    chk("done_one_pulse", 32'(done), 32'h0);
    wait_done(lat, busy_cnt);
    chk("mult_lat", 32'(lat), 32'd33);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    start_op(OP_DIVU, 32'd7, 32'd2);
    wait_done(lat, busy_cnt);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, busy_cnt);
    chk("div_neg_dividend_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_dividend_hi", hi, 32'hFFFFFFFF);

    start_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done(lat, busy_cnt);
    chk("div_neg_divisor_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_divisor_hi", hi, 32'd1);

    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, busy_cnt);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);

    start_op(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, busy_cnt);
    chk("divu_zero_lat", 32'(lat), 32'd33);
    chk("divu_zero_lo", lo, 32'hFFFFFFFF);
    chk("divu_zero_hi", hi, 32'd5);

    // Move to HI while idle
    start_op(OP_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'h0);
    chk("mthi_done", 32'(done), 32'h0);

    // MTLO and MULTU while busy are ignored
    start_op(OP_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start_op(OP_MTLO, 32'hDEADBEEF, 32'h0);
    chk("mtlo_busy_ignored", lo, 32'hFFFFFFFF);
    start_op(OP_MULTU, 32'd100, 32'd100);
    wait_done(lat, busy_cnt);
    chk("busy_ignore_hi", hi, 32'h0);
    chk("busy_ignore_lo", lo, 32'd12);

    // Reserved op ignored
    start_op(3'b110, 32'h1, 32'h2);
    chk("reserved_busy", 32'(busy), 32'h0);
    chk("reserved_lo", lo, 32'd12);

    // Cancel in idle blocks a simultaneous MTHI
    cancel = 1'b1;
    start_op(OP_MTHI, 32'h55555555, 32'h0);
    cancel = 1'b0;
    chk("cancel_idle_hi", hi, 32'h0);

    // Cancel mid-calculation
    start_op(OP_MTHI, 32'hAAAA0000, 32'h0);
    start_op(OP_MTLO, 32'h0000BBBB, 32'h0);
    start_op(OP_MULT, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'h0);
    chk("cancel_done", 32'(done), 32'h0);
    watch_no_done(40, done_seen);
    chk("cancel_no_done", 32'(done_seen), 32'h0);
    chk("cancel_hi", hi, 32'hAAAA0000);
    chk("cancel_lo", lo, 32'h0000BBBB);

    // Reset mid-calculation
    start_op(OP_MULT, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    watch_no_done(40, done_seen);
    chk("midrst_no_done", 32'(done_seen), 32'h0);

    // Cancel coincident with FINISH (sampled at the 33rd edge after issue)
    start_op(OP_MTHI, 32'h11112222, 32'h0);
    start_op(OP_MTLO, 32'h33334444, 32'h0);
    start_op(OP_MULTU, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    chk("finish_still_busy", 32'(busy), 32'h1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("finish_cancel_busy", 32'(busy), 32'h0);
    chk("finish_cancel_done", 32'(done), 32'h0);
    watch_no_done(5, done_seen);
    chk("finish_cancel_no_done", 32'(done_seen), 32'h0);
    chk("finish_cancel_hi", hi, 32'h11112222);
    chk("finish_cancel_lo", lo, 32'h33334444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
